// File: rtl/dma_write_controller.sv
// Device-to-host DMA write engine: fetches PCIe-legal chunks from device memory over
// AXI4 read, buffers each chunk and hands it to the TLP engine as one memory-write request.
module dma_write_controller #(
    parameter int unsigned FIFO_DEPTH = 64,
    parameter logic [3:0]  AXI_ID     = 4'd0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [15:0]  pcie_dcommand,
    input  logic [31:0]  dma_write_host_address,
    input  logic [31:0]  dma_write_device_address,
    input  logic [31:0]  dma_write_length,
    input  logic         dma_write_start,
    output logic         dma_write_busy,
    output logic         dma_write_finished,
    output logic         dma_write_error,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic [3:0]   arid,
    output logic         arvalid,
    input  logic         arready,
    input  logic [127:0] rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready,
    output logic [31:0]  dma_write_addr,
    output logic [9:0]   dma_write_len,
    output logic         dma_write_valid,
    input  logic         dma_write_done,
    output logic [127:0] dma_write_data,
    output logic         dma_write_data_valid,
    input  logic         dma_write_data_rd
);

    localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam logic [31:0] FIFO_BYTES = 32'(FIFO_DEPTH * 16);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_AR, S_RDAT, S_REQ, S_FIN} state_t;

    state_t state, state_nxt;

    logic [31:0] host_addr, dev_addr, remaining;
    logic [12:0] chunk;
    logic [8:0]  beat_cnt;

    logic [127:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt, fifo_cnt_nxt;

    logic [31:0] mps_c, bound_c, chunk_c, rem_after_c;
    logic [7:0]  arlen_c;
    logic        push_c, pop_c, count_last_c, rd_end_c, rd_err_c, done_c, leftover_c, err_nxt_c;

    assign arsize  = 3'b100;
    assign arburst = 2'b01;
    assign arid    = AXI_ID;

    // Chunk = min(remaining, MPS, FIFO capacity, bytes left before the host 4 KB boundary)
    always_comb begin
        mps_c = 32'd128;
        if (pcie_dcommand[7:5] <= 3'd5) mps_c = 32'd128 << pcie_dcommand[7:5];
        bound_c = 32'd4096 - {20'd0, host_addr[11:0]};
        chunk_c = remaining;
        if (mps_c < chunk_c)      chunk_c = mps_c;
        if (FIFO_BYTES < chunk_c) chunk_c = FIFO_BYTES;
        if (bound_c < chunk_c)    chunk_c = bound_c;
        arlen_c = 8'((chunk_c >> 4) - 32'd1);
    end

    assign push_c       = (state == S_RDAT) && rvalid && rready;
    assign pop_c        = dma_write_data_valid && dma_write_data_rd;
    assign count_last_c = (beat_cnt == {1'b0, arlen});
    assign rd_end_c     = push_c && (rlast || count_last_c);
    assign rd_err_c     = push_c && ((rresp != 2'b00) || (rlast != count_last_c));
    assign done_c       = (state == S_REQ) && dma_write_done;
    // Data still buffered when the engine reports done means it under-consumed the chunk
    assign leftover_c   = done_c && ((fifo_cnt - CNT_W'(pop_c)) != '0);
    assign rem_after_c  = remaining - {19'd0, chunk};
    assign err_nxt_c    = dma_write_error || leftover_c;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (dma_write_start) state_nxt = S_CALC;
            S_CALC: state_nxt = (remaining == '0) ? S_FIN : S_AR;
            S_AR:   if (arready) state_nxt = S_RDAT;
            S_RDAT: if (rd_end_c) state_nxt = S_REQ;
            S_REQ:  if (done_c) state_nxt = ((rem_after_c != '0) && !err_nxt_c) ? S_CALC : S_FIN;
            S_FIN:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Transfer bookkeeping and registered handshake outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            host_addr          <= '0;
            dev_addr           <= '0;
            remaining          <= '0;
            chunk              <= '0;
            beat_cnt           <= '0;
            dma_write_busy     <= 1'b0;
            dma_write_finished <= 1'b0;
            dma_write_error    <= 1'b0;
            araddr             <= '0;
            arlen              <= '0;
            arvalid            <= 1'b0;
            rready             <= 1'b0;
            dma_write_addr     <= '0;
            dma_write_len      <= '0;
            dma_write_valid    <= 1'b0;
        end else begin
            dma_write_finished <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (dma_write_start) begin
                        host_addr       <= {dma_write_host_address[31:4], 4'b0000};
                        dev_addr        <= {dma_write_device_address[31:4], 4'b0000};
                        remaining       <= {dma_write_length[31:4], 4'b0000};
                        dma_write_error <= 1'b0;
                        dma_write_busy  <= 1'b1;
                    end
                end
                S_CALC: begin
                    chunk          <= chunk_c[12:0];
                    araddr         <= dev_addr;
                    arlen          <= arlen_c;
                    dma_write_addr <= host_addr;
                    dma_write_len  <= chunk_c[11:2];
                    beat_cnt       <= '0;
                    if (remaining == '0) begin
                        dma_write_finished <= 1'b1;
                        dma_write_busy     <= 1'b0;
                    end else begin
                        arvalid <= 1'b1;
                    end
                end
                S_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end
                end
                S_RDAT: begin
                    if (push_c) beat_cnt <= beat_cnt + 9'd1;
                    if (rd_err_c) dma_write_error <= 1'b1;
                    if (rd_end_c) begin
                        rready          <= 1'b0;
                        dma_write_valid <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (done_c) begin
                        dma_write_valid <= 1'b0;
                        host_addr       <= host_addr + {19'd0, chunk};
                        dev_addr        <= dev_addr + {19'd0, chunk};
                        remaining       <= rem_after_c;
                        if (leftover_c) dma_write_error <= 1'b1;
                        if (state_nxt == S_FIN) begin
                            dma_write_finished <= 1'b1;
                            dma_write_busy     <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        fifo_cnt_nxt = fifo_cnt + CNT_W'(push_c) - CNT_W'(pop_c);
        if (leftover_c) fifo_cnt_nxt = '0;
    end

    // Chunk FIFO pointers; a flush drops whatever the engine left behind
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr               <= '0;
            rd_ptr               <= '0;
            fifo_cnt             <= '0;
            dma_write_data_valid <= 1'b0;
        end else begin
            fifo_cnt             <= fifo_cnt_nxt;
            dma_write_data_valid <= (fifo_cnt_nxt != '0);
            if (leftover_c) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_c) fifo_mem[wr_ptr] <= rdata;
    end

    assign dma_write_data = dma_write_data_valid ? fifo_mem[rd_ptr] : '0;

    logic unused_ok;
    assign unused_ok = ^{pcie_dcommand[15:8], pcie_dcommand[4:0], dma_write_host_address[3:0],
                         dma_write_device_address[3:0], dma_write_length[3:0]};

endmodule

// File: tb/tb_dma_write_controller.sv
// Randomized scoreboard bench for dma_write_controller: AXI slave and TLP engine models,
// expectations computed from the chunking rules with plain arithmetic.
module tb_dma_write_controller;

    localparam int unsigned FIFO_DEPTH = 64;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic [15:0]  pcie_dcommand;
    logic [31:0]  dma_write_host_address, dma_write_device_address, dma_write_length;
    logic         dma_write_start;
    logic         dma_write_busy, dma_write_finished, dma_write_error;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [3:0]   arid;
    logic         arvalid, arready;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;
    logic [31:0]  dma_write_addr;
    logic [9:0]   dma_write_len;
    logic         dma_write_valid, dma_write_done;
    logic [127:0] dma_write_data;
    logic         dma_write_data_valid, dma_write_data_rd;

    dma_write_controller #(.FIFO_DEPTH(FIFO_DEPTH), .AXI_ID(4'd0)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .pcie_dcommand(pcie_dcommand),
        .dma_write_host_address(dma_write_host_address),
        .dma_write_device_address(dma_write_device_address),
        .dma_write_length(dma_write_length), .dma_write_start(dma_write_start),
        .dma_write_busy(dma_write_busy), .dma_write_finished(dma_write_finished),
        .dma_write_error(dma_write_error), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arid(arid), .arvalid(arvalid), .arready(arready), .rdata(rdata),
        .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .dma_write_addr(dma_write_addr), .dma_write_len(dma_write_len),
        .dma_write_valid(dma_write_valid), .dma_write_done(dma_write_done),
        .dma_write_data(dma_write_data), .dma_write_data_valid(dma_write_data_valid),
        .dma_write_data_rd(dma_write_data_rd)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed { logic [31:0] addr; logic [7:0] len; } ar_t;
    typedef struct packed { logic [31:0] addr; logic [9:0] len; } req_t;

    ar_t          exp_ar[$];
    req_t         exp_req[$];
    logic [127:0] exp_data[$];

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned cyc = 0;

    // Stimulus knobs
    int ar_stall  = 0;
    int r_gap_pct = 0;
    int rd_pct    = 100;
    int err_burst = -1;
    int err_beat  = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] mem_word(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a, a * 32'd3, a + 32'h1234_5678};
    endfunction

    // Reference model: split the transfer into chunks and queue every expected response
    task automatic plan(input logic [2:0] code, input logic [31:0] host, input logic [31:0] dev,
                        input logic [31:0] len, input int err_chunk, output bit exp_err);
        logic [31:0] rem, h, d, mps, c, bnd;
        ar_t  a;
        req_t r;
        int   k;
        rem = len & ~32'hF;
        h   = host & ~32'hF;
        d   = dev & ~32'hF;
        mps = (code <= 3'd5) ? (32'd128 << code) : 32'd128;
        exp_err = 1'b0;
        k = 0;
        while (rem != 0 && !exp_err) begin
            bnd = 32'd4096 - (h & 32'hFFF);
            c = rem;
            if (mps < c) c = mps;
            if (FIFO_DEPTH * 16 < c) c = FIFO_DEPTH * 16;
            if (bnd < c) c = bnd;
            a.addr = d; a.len = 8'(c / 16 - 1);
            r.addr = h; r.len = 10'(c / 4);
            exp_ar.push_back(a);
            exp_req.push_back(r);
            for (int i = 0; i < int'(c / 16); i++) exp_data.push_back(mem_word(d + 32'(i * 16)));
            if (k == err_chunk) exp_err = 1'b1;
            h += c; d += c; rem -= c; k++;
        end
    endtask

    // AXI read slave: stalls AR, gaps R, injects an error response on request
    ar_t pend[$];
    ar_t cur;
    bit  cur_act = 0, r_x = 0;
    int  beat = 0, stall_cnt = 0, burst_no = 0, cur_idx = 0;

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            pend.delete();
            cur_act = 0; r_x = 0; stall_cnt = 0; burst_no = 0;
            arready = 0; rvalid = 0; rlast = 0; rresp = 2'b00; rdata = '0;
        end else begin
            if (dma_write_finished) burst_no = 0;
            if (arvalid) begin
                if (stall_cnt < ar_stall) begin arready = 0; stall_cnt++; end
                else arready = 1;
            end else begin
                arready = 0; stall_cnt = 0;
            end
            if (arvalid && arready) begin
                if (exp_ar.size() == 0) chk("ar_unexpected", {araddr, arlen}, 0);
                else begin
                    ar_t e;
                    e = exp_ar.pop_front();
                    chk("ar_addr", araddr, e.addr);
                    chk("ar_len", arlen, e.len);
                end
                chk("ar_const", {arsize, arburst, arid}, {3'b100, 2'b01, 4'd0});
                pend.push_back({araddr, arlen});
            end
            if (r_x) begin
                rvalid = 0;
                beat++;
                if (beat > int'(cur.len)) cur_act = 0;
            end
            if (!rvalid) begin
                if (!cur_act && pend.size() > 0) begin
                    cur = pend.pop_front(); cur_act = 1; beat = 0;
                    cur_idx = burst_no; burst_no++;
                end
                if (cur_act && $urandom_range(0, 99) >= r_gap_pct) begin
                    rvalid = 1;
                    rdata  = mem_word(cur.addr + 32'(beat * 16));
                    rlast  = (beat == int'(cur.len));
                    rresp  = (cur_idx == err_burst && beat == err_beat) ? 2'b10 : 2'b00;
                end
            end
            r_x = rvalid && rready;
        end
    end

    // TLP engine model: checks each request, pops its data, then pulses done
    req_t req;
    bit   ractive = 0;
    int   need = 0, got = 0;

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            ractive = 0; dma_write_done = 0; dma_write_data_rd = 0;
        end else begin
            if (dma_write_done) begin
                dma_write_done = 0; ractive = 0;
            end else if (dma_write_valid && !ractive) begin
                if (exp_req.size() == 0) chk("req_unexpected", {dma_write_addr, dma_write_len}, 0);
                else begin
                    req = exp_req.pop_front();
                    chk("req_addr", dma_write_addr, req.addr);
                    chk("req_len", dma_write_len, req.len);
                end
                ractive = 1; got = 0;
                need = (dma_write_len == 10'd0) ? 256 : int'(dma_write_len) / 4;
            end
            dma_write_data_rd = ractive && !dma_write_done && ($urandom_range(0, 99) < rd_pct);
            if (dma_write_data_valid && dma_write_data_rd) begin
                if (exp_data.size() == 0) chk("data_unexpected", dma_write_data, 0);
                else chk("data", dma_write_data, exp_data.pop_front());
                got++;
            end
            if (ractive && !dma_write_done && got == need && $urandom_range(0, 1) == 1)
                dma_write_done = 1;
        end
    end

    task automatic run_xfer(input string tag, input logic [2:0] code, input logic [31:0] host,
                            input logic [31:0] dev, input logic [31:0] len, input int err_chunk);
        bit exp_err, seen_ar, seen_req;
        int first_ar, fin_at;
        int unsigned s;
        plan(code, host, dev, len, err_chunk, exp_err);
        err_burst = err_chunk;
        pcie_dcommand = {8'h00, code, 5'h00};
        dma_write_host_address = host;
        dma_write_device_address = dev;
        dma_write_length = len;
        dma_write_start = 1;
        s = cyc;
        @(negedge i_clk);
        dma_write_start = 0;
        chk({tag, "_busy"}, dma_write_busy, 1);
        chk({tag, "_err_clr"}, dma_write_error, 0);
        first_ar = -1; fin_at = -1; seen_ar = 0; seen_req = 0;
        for (int i = 0; i < 20000; i++) begin
            if (arvalid && first_ar < 0) first_ar = int'(cyc - s);
            if (arvalid) seen_ar = 1;
            if (dma_write_valid) seen_req = 1;
            if (dma_write_finished) begin
                fin_at = int'(cyc - s);
                break;
            end
            @(negedge i_clk);
        end
        chk({tag, "_finished"}, fin_at >= 0, 1);
        chk({tag, "_error"}, dma_write_error, exp_err);
        chk({tag, "_busy_end"}, dma_write_busy, 0);
        if ((len & ~32'hF) == 0) begin
            chk({tag, "_fin_lat"}, fin_at, 2);
            chk({tag, "_no_axi"}, seen_ar, 0);
            chk({tag, "_no_pcie"}, seen_req, 0);
        end else begin
            chk({tag, "_ar_lat"}, first_ar, 2);
        end
        repeat (3) @(negedge i_clk);
        chk({tag, "_ar_left"}, exp_ar.size(), 0);
        chk({tag, "_req_left"}, exp_req.size(), 0);
        chk({tag, "_data_left"}, exp_data.size(), 0);
        chk({tag, "_fifo_empty"}, dma_write_data_valid, 0);
        exp_ar.delete(); exp_req.delete(); exp_data.delete();
        err_burst = -1;
    endtask

    initial begin
        bit e;
        i_rst_n = 0;
        pcie_dcommand = '0;
        dma_write_host_address = '0;
        dma_write_device_address = '0;
        dma_write_length = '0;
        dma_write_start = 0;
        repeat (3) @(negedge i_clk);
        chk("rst_ctrl", {dma_write_busy, dma_write_finished, dma_write_error, arvalid, rready,
                         dma_write_valid, dma_write_data_valid}, 0);
        chk("rst_regs", {araddr, arlen, dma_write_addr, dma_write_len}, 0);
        i_rst_n = 1;
        @(negedge i_clk);

        run_xfer("single", 3'd0, 32'h1000, 32'h0, 32'd64, -1);
        run_xfer("mps_split", 3'd1, 32'h0, 32'h8000, 32'd600, -1);
        run_xfer("cross4k", 3'd5, 32'hFC0, 32'h4000, 32'd256, -1);
        run_xfer("mps_code7", 3'd7, 32'h2000, 32'h10, 32'd300, -1);

        ar_stall = 5; r_gap_pct = 50; rd_pct = 50;
        run_xfer("backpress", 3'd2, 32'h2000, 32'h100, 32'd1024, -1);

        ar_stall = 1; r_gap_pct = 20; rd_pct = 70; err_beat = 1;
        run_xfer("rresp_err", 3'd1, 32'h0, 32'h0, 32'd600, 0);
        run_xfer("after_err", 3'd1, 32'h0, 32'h0, 32'd600, -1);

        run_xfer("zero_len", 3'd0, 32'h1000, 32'h0, 32'h0000_000F, -1);
        run_xfer("addr_wrap", 3'd3, 32'hFFFF_FF80, 32'hFFFF_FFC0, 32'd256, -1);

        for (int t = 0; t < 8; t++) begin
            ar_stall  = int'($urandom_range(0, 3));
            r_gap_pct = int'($urandom_range(0, 60));
            rd_pct    = int'($urandom_range(30, 100));
            run_xfer("random", 3'($urandom_range(0, 7)), $urandom, $urandom,
                     32'($urandom_range(0, 3000)), -1);
        end

        // Reset in the middle of a chunk read
        ar_stall = 0; r_gap_pct = 60; rd_pct = 50;
        plan(3'd2, 32'h3000, 32'h100, 32'd512, -1, e);
        pcie_dcommand = {8'h00, 3'd2, 5'h00};
        dma_write_host_address = 32'h3000;
        dma_write_device_address = 32'h100;
        dma_write_length = 32'd512;
        dma_write_start = 1;
        @(negedge i_clk);
        dma_write_start = 0;
        begin
            bit reached;
            reached = 0;
            for (int i = 0; i < 2000 && !reached; i++) begin
                if (rready && dma_write_data_valid) reached = 1;
                else @(negedge i_clk);
            end
            chk("rst_mid_reached", reached, 1);
        end
        i_rst_n = 0;
        #1;
        chk("rst_mid_ctrl", {dma_write_busy, dma_write_finished, dma_write_error, arvalid, rready,
                             dma_write_valid, dma_write_data_valid}, 0);
        chk("rst_mid_regs", {araddr, arlen, dma_write_addr, dma_write_len}, 0);
        chk("rst_mid_data", dma_write_data, 0);
        exp_ar.delete(); exp_req.delete(); exp_data.delete();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1;
        @(negedge i_clk);
        chk("rst_mid_fifo", dma_write_data_valid, 0);
        r_gap_pct = 10; rd_pct = 80;
        run_xfer("post_rst", 3'd0, 32'h1000, 32'h0, 32'd192, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
